maze_store: RTL and testbench
=============================

Name: maze_store

Overview:
- Maze memory that the maze-walking solver reads and writes through `row`/`col`/`maze_oe`/`maze_we`/`maze_in`.
- Holds a 2^maze_width x 2^maze_width grid of 2-bit cells: 0 = free, 1 = wall, 2 = visited.
- Loaded serially in raster order by the testbench or host before a solve.
- Answers solver reads one cycle after `maze_oe`, marks cells visited on `maze_we`, and exposes a debug read port plus a visited-cell counter for checking.

Parameters:
- maze_width, 6, bits per row/col index; grid is (1<<maze_width) x (1<<maze_width) cells.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- row  input  maze_width  solver row select.
- col  input  maze_width  solver column select.
- maze_oe  input  1  solver read enable, sampled at posedge.
- maze_we  input  1  solver write enable, sampled at posedge; marks [row,col] visited.
- maze_in  output  1  read data to solver: 1 = wall, 0 = free or visited; registered.
- load_start  input  1  pulse: begin a new maze load.
- load_valid  input  1  load_bit is valid this cycle.
- load_bit  input  1  cell content in raster order (1 = wall, 0 = free).
- ready  output  1  maze loaded; solver accesses honoured.
- visited_count  output  2*maze_width+1  number of distinct cells marked visited since last load.
- dbg_row  input  maze_width  debug read row.
- dbg_col  input  maze_width  debug read column.
- dbg_cell  output  2  registered cell code at [dbg_row,dbg_col], 1-cycle latency.
- wall_write_err  output  1  sticky flag; present only with the optional feature (see below).

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, ready=0, maze_in=1, visited_count=0, dbg_cell=0, load address=0, wall_write_err=0.
  - Cell array is not reset.
- States:
  - IDLE: waits for load_start; solver accesses ignored; maze_in held 1.
  - LOAD: each cycle with load_valid=1 writes {1'b0,load_bit} to address (r,c) and advances c, wrapping c to 0 with r+1. Accepting the last cell (r=c=all ones) moves to READY, ready=1 next cycle. load_valid=0 stalls; no timeout. Solver accesses ignored; maze_in held 1.
  - READY: serves the solver. Stays until load_start or rst.
- load_start in any state (including mid-LOAD):
  - address goes to 0, visited_count to 0, ready to 0, state to LOAD.
  - A load_valid in the same cycle as load_start is ignored.
- Solver read in READY:
  - maze_oe=1 at edge N gives maze_in = (cell==1) at edge N, visible during cycle N+1.
  - maze_oe=0 holds the previous maze_in.
- Solver write in READY: maze_we=1 sets the cell to 2. visited_count increments only if the cell was not already 2.
- Simultaneous maze_oe and maze_we to the same cell are read-before-write: maze_in reflects the old content.
- Write to a wall cell (cell==1): overwritten to 2 and counted unless the optional feature is enabled.
- Indices always lie within the grid; no range check is needed.
- visited_count saturates at 2^(2*maze_width).
- Debug port: active in all states; dbg_cell = cell[dbg_row,dbg_col] registered every cycle, read-before-write.

Optional Feature:
- Macro: MAZE_WALL_PROTECT_EN.
- Defined:
  - maze_we to a wall cell is dropped: cell stays 1, no count.
  - wall_write_err goes to 1 on the next edge and stays until rst or load_start.
- Undefined:
  - wall writes overwrite the cell to 2.
  - wall_write_err port is absent.

Test Plan:
- rst, then maze_oe=1 without a load -> maze_in=1, ready=0, visited_count=0.
- Load 4096 bits (walls on the border except a free cell at [0,5]; all else free) -> ready=1 one cycle after the final load_valid; dbg reads return 1 at [0,0] and 0 at [0,5].
- In READY, maze_oe at [3,3] (free) -> maze_in=0 next cycle. Then maze_oe at [0,0] -> maze_in=1. maze_oe low for 3 cycles -> maze_in holds 1.
- maze_we at [3,3] twice, then [3,4] once -> dbg_cell[3,3]=2, visited_count=2. Same-cycle oe+we at [5,5] -> maze_in=0, then cell=2.
- load_start after 1000 load bits, then a full 4096-bit load -> ready=0 during the load, counts restart, final contents match the second load only, visited_count=0.
- MAZE_WALL_PROTECT_EN defined, maze_we at [0,0] (wall) -> dbg_cell[0,0]=1, visited_count unchanged, wall_write_err=1 until load_start. Macro undefined -> cell=2, count+1.

Source files
------------

// File: rtl/maze_store.sv
// Maze cell store for the maze-walking solver: serial raster load, solver read/mark, debug port.
// Optional build macro MAZE_WALL_PROTECT_EN: drop solver writes to walls and raise wall_write_err.
module maze_store #(
  parameter int maze_width = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [maze_width-1:0]   row,
  input  logic [maze_width-1:0]   col,
  input  logic                    maze_oe,
  input  logic                    maze_we,
  output logic                    maze_in,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic                    load_bit,
  output logic                    ready,
  output logic [2*maze_width:0]   visited_count,
  input  logic [maze_width-1:0]   dbg_row,
  input  logic [maze_width-1:0]   dbg_col,
  output logic [1:0]              dbg_cell
`ifdef MAZE_WALL_PROTECT_EN
  ,
  output logic                    wall_write_err
`endif
);

  // state   | meaning
  // IDLE    | no maze loaded, solver ignored
  // LOAD    | accepting raster bits, solver ignored
  // READY   | maze loaded, solver served
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam int AW    = 2 * maze_width;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] CELL_WALL    = 2'd1;
  localparam logic [1:0] CELL_VISITED = 2'd2;
  localparam logic [AW:0] CNT_MAX     = {1'b1, {AW{1'b0}}};

  logic [1:0]    cells_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          maze_in_q, maze_in_d;
  logic [1:0]    dbg_cell_q;
  logic          err_q, err_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic [AW-1:0] sol_addr;
  logic [1:0]    sol_cell;
  logic          wall_block;

  assign sol_addr = {row, col};
  assign sol_cell = cells_q[sol_addr];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    maze_in_d  = maze_in_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    wr_addr    = addr_q;
    wr_data    = {1'b0, load_bit};
`ifdef MAZE_WALL_PROTECT_EN
    wall_block = (sol_cell == CELL_WALL);
`else
    wall_block = 1'b0;
`endif

    // A fresh load overrides everything, including a load_valid in the same cycle.
    if (load_start) begin
      state_d   = S_LOAD;
      addr_d    = '0;
      cnt_d     = '0;
      maze_in_d = 1'b1;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: maze_in_d = 1'b1;
        S_LOAD: begin
          maze_in_d = 1'b1;
          if (load_valid) begin
            wr_en  = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) state_d = S_READY;
          end
        end
        S_READY: begin
          if (maze_oe) maze_in_d = (sol_cell == CELL_WALL);
          if (maze_we) begin
            if (wall_block) begin
              err_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              wr_addr = sol_addr;
              wr_data = CELL_VISITED;
              if (sol_cell != CELL_VISITED && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      maze_in_q  <= 1'b1;
      dbg_cell_q <= 2'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      maze_in_q  <= maze_in_d;
      dbg_cell_q <= cells_q[{dbg_row, dbg_col}];
      err_q      <= err_d;
    end
  end

  // Cell array has no reset; contents are only meaningful after a complete load.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) cells_q[wr_addr] <= wr_data;
  end

  assign maze_in       = maze_in_q;
  assign ready         = (state_q == S_READY);
  assign visited_count = cnt_q;
  assign dbg_cell      = dbg_cell_q;
`ifdef MAZE_WALL_PROTECT_EN
  assign wall_write_err = err_q;
`endif

endmodule

// File: tb/tb_maze_store.sv
// Randomized self-checking bench for maze_store against an array-based reference model.
// Build with MAZE_WALL_PROTECT_EN defined to exercise the wall-protect variant.
module tb_maze_store;
  localparam int MW = 6;
  localparam int N  = 1 << (2 * MW);
  localparam int SIDE = 1 << MW;

  logic          clk = 1'b0;
  logic          rst;
  logic [MW-1:0] row, col, dbg_row, dbg_col;
  logic          maze_oe, maze_we, maze_in;
  logic          load_start, load_valid, load_bit;
  logic          ready;
  logic [2*MW:0] visited_count;
  logic [1:0]    dbg_cell;
`ifdef MAZE_WALL_PROTECT_EN
  logic          wall_write_err;
`endif

  maze_store #(.maze_width(MW)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
    .ready(ready), .visited_count(visited_count),
    .dbg_row(dbg_row), .dbg_col(dbg_col), .dbg_cell(dbg_cell)
`ifdef MAZE_WALL_PROTECT_EN
    , .wall_write_err(wall_write_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ref_cell [N];
  int ref_count;
  int ref_err;
  int exp_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err();
`ifdef MAZE_WALL_PROTECT_EN
    chk("wall_write_err", 32'(wall_write_err), 32'(ref_err));
`endif
  endtask

  // Solver write semantics from the cell rules: walls are protected only in the protect build.
  task automatic model_write(input int a);
`ifdef MAZE_WALL_PROTECT_EN
    if (ref_cell[a] == 1) begin
      ref_err = 1;
      return;
    end
`endif
    if (ref_cell[a] != 2 && ref_count < N) ref_count++;
    ref_cell[a] = 2;
  endtask

  function automatic int pattern_bit(input int mode, input int idx);
    int r, c;
    r = idx / SIDE;
    c = idx % SIDE;
    if (mode == 0) begin
      if (r == 0 && c == 5) return 0;
      return (r == 0 || c == 0 || r == SIDE - 1 || c == SIDE - 1) ? 1 : 0;
    end
    return ($urandom_range(0, 2) == 0) ? 1 : 0;
  endfunction

  // abort_after < 0 means a complete load; otherwise stop feeding after that many bits.
  task automatic load_maze(input int mode, input int abort_after);
    int b;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_bit   = 1'b1;
    tick();
    load_start = 1'b0;
    ref_count  = 0;
    ref_err    = 0;
    chk("load_ready_low", 32'(ready), 32'd0);
    chk("load_count_clr", 32'(visited_count), 32'd0);
    chk_err();
    maze_oe = 1'b1;
    maze_we = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        load_valid = 1'b0;
        maze_oe = 1'b0;
        maze_we = 1'b0;
        return;
      end
      while ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      b = pattern_bit(mode, i);
      load_valid = 1'b1;
      load_bit   = b[0];
      row = MW'($urandom);
      col = MW'($urandom);
      tick();
      ref_cell[i] = b;
      if (i % 512 == 0) begin
        chk("load_ready_mid", 32'(ready), 32'd0);
        chk("load_maze_in", 32'(maze_in), 32'd1);
        chk("load_count_mid", 32'(visited_count), 32'd0);
      end
    end
    load_valid = 1'b0;
    maze_oe = 1'b0;
    maze_we = 1'b0;
    chk("ready_after_load", 32'(ready), 32'd1);
    chk("count_after_load", 32'(visited_count), 32'd0);
    exp_in = 1;
  endtask

  task automatic dbg_read(input int r, input int c, input string tag);
    dbg_row = MW'(r);
    dbg_col = MW'(c);
    tick();
    chk(tag, 32'(dbg_cell), 32'(ref_cell[r * SIDE + c]));
  endtask

  // One solver cycle with the given enables; checks read data, count and error flag.
  task automatic sol_op(input int r, input int c, input bit oe, input bit we, input string tag);
    int a;
    a = r * SIDE + c;
    row = MW'(r);
    col = MW'(c);
    maze_oe = oe;
    maze_we = we;
    if (oe) exp_in = (ref_cell[a] == 1) ? 1 : 0;
    tick();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    if (we) model_write(a);
    chk(tag, 32'(maze_in), 32'(exp_in));
    chk("visited_count", 32'(visited_count), 32'(ref_count));
    chk_err();
  endtask

  initial begin
    rst = 1'b1;
    row = '0; col = '0; dbg_row = '0; dbg_col = '0;
    maze_oe = 1'b0; maze_we = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    ref_count = 0;
    ref_err = 0;
    exp_in = 1;
    tick();
    tick();
    chk("rst_maze_in", 32'(maze_in), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_count", 32'(visited_count), 32'd0);
    chk("rst_dbg_cell", 32'(dbg_cell), 32'd0);
    chk_err();
    rst = 1'b0;

    maze_oe = 1'b1;
    maze_we = 1'b1;
    repeat (3) tick();
    maze_oe = 1'b0;
    maze_we = 1'b0;
    chk("idle_maze_in", 32'(maze_in), 32'd1);
    chk("idle_ready", 32'(ready), 32'd0);
    chk("idle_count", 32'(visited_count), 32'd0);

    load_maze(0, -1);
    dbg_read(0, 0, "dbg_wall_00");
    dbg_read(0, 5, "dbg_free_05");

    sol_op(3, 3, 1'b1, 1'b0, "read_free_33");
    sol_op(0, 0, 1'b1, 1'b0, "read_wall_00");
    for (int k = 0; k < 3; k++) sol_op(7, 7, 1'b0, 1'b0, "hold_maze_in");

    sol_op(3, 3, 1'b0, 1'b1, "write_33a");
    sol_op(3, 3, 1'b0, 1'b1, "write_33b");
    sol_op(3, 4, 1'b0, 1'b1, "write_34");
    dbg_read(3, 3, "dbg_visited_33");
    chk("count_two", 32'(visited_count), 32'd2);

    sol_op(5, 5, 1'b1, 1'b1, "rbw_maze_in_55");
    dbg_read(5, 5, "dbg_visited_55");
    sol_op(5, 5, 1'b1, 1'b0, "read_visited_55");

    sol_op(0, 0, 1'b0, 1'b1, "wall_write_00");
    dbg_read(0, 0, "dbg_after_wall_write");
    sol_op(0, 0, 1'b1, 1'b0, "read_after_wall_write");

    load_maze(1, 1000);
    load_maze(1, -1);
    chk_err();
    for (int a = 0; a < N; a++) dbg_read(a / SIDE, a % SIDE, "dbg_sweep");

    // Small index range gives repeated hits on the same cells.
    for (int k = 0; k < 400; k++) begin
      int r, c;
      bit oe, we;
      r  = $urandom_range(0, 7);
      c  = $urandom_range(0, 7);
      oe = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      sol_op(r, c, oe, we, "rand_op");
      if (k % 8 == 0) dbg_read($urandom_range(0, 7), $urandom_range(0, 7), "rand_dbg");
    end
    for (int a = 0; a < 8 * SIDE; a++) dbg_read(a / SIDE, a % SIDE, "dbg_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
